// File: rtl/next_pc_sequencer_if.sv
// Decode-to-sequencer bus: control-transfer requests in, next-PC/link/status out.
interface next_pc_sequencer_if;
    logic [31:0] pc;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] rs_data;

    logic [31:0] new_pc;
    logic [31:0] link_pc;
    logic        in_delay_slot;
    logic        target_misaligned;
    logic        active;

    // Decode/PC side drives requests and observes the next PC.
    modport master (
        output pc, branch_taken, branch_imm, jump, jump_index, jump_reg, rs_data,
        input  new_pc, link_pc, in_delay_slot, target_misaligned, active
    );

    // Sequencer side.
    modport slave (
        input  pc, branch_taken, branch_imm, jump, jump_index, jump_reg, rs_data,
        output new_pc, link_pc, in_delay_slot, target_misaligned, active
    );
endinterface

// File: rtl/next_pc_sequencer.sv
// MIPS next-PC sequencer: computes control-transfer targets, holds the chosen target
// across the branch delay slot, produces the link address and detects halt.
module next_pc_sequencer #(
    parameter logic [31:0] HALT_ADDR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,       // active-low, asynchronous
    input  logic               clk_enable,
    next_pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        StSeq   = 2'b00,
        StDelay = 2'b01,
        StHalt  = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] target_q, target_d;

    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic [31:0] branch_off;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] target;
    logic        req;

    // Sequential addresses and candidate targets, all modulo 2^32.
    always_comb begin
        pc_plus4      = bus.pc + 32'd4;
        pc_plus8      = bus.pc + 32'd8;
        branch_off    = {{14{bus.branch_imm[15]}}, bus.branch_imm, 2'b00};
        branch_target = pc_plus4 + branch_off;
        jump_target   = {pc_plus4[31:28], bus.jump_index, 2'b00};
        req           = bus.jump_reg | bus.jump | bus.branch_taken;
        // Register jump beats J-type, which beats a conditional branch.
        if (bus.jump_reg) begin
            target = bus.rs_data;
        end else if (bus.jump) begin
            target = jump_target;
        end else begin
            target = branch_target;
        end
    end

    // Next-state logic and per-state outputs.
    always_comb begin
        state_d               = state_q;
        target_d              = target_q;
        bus.new_pc            = pc_plus4;
        bus.link_pc           = pc_plus8;
        bus.in_delay_slot     = 1'b0;
        bus.target_misaligned = 1'b0;
        bus.active            = 1'b1;

        unique case (state_q)
            StSeq: begin
                bus.target_misaligned = req & (target[1:0] != 2'b00);
                if (clk_enable && req) begin
                    target_d = target;
                    state_d  = StDelay;
                end
            end
            StDelay: begin
                // Requests decoded in the delay slot are dropped.
                bus.new_pc        = target_q;
                bus.in_delay_slot = 1'b1;
                if (clk_enable) begin
                    state_d = (target_q == HALT_ADDR) ? StHalt : StSeq;
                end
            end
            StHalt: begin
                bus.new_pc = bus.pc;
                bus.active = 1'b0;
            end
            default: begin
                // Unreachable encoding recovers to sequential flow.
                state_d = StSeq;
            end
        endcase
    end

    // State and latched target; reset discards any pending transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StSeq;
            target_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

endmodule

// File: tb/tb_next_pc_sequencer.sv
// Directed bench for next_pc_sequencer with hand-computed expectations.
module tb_next_pc_sequencer;

    logic clk;
    logic reset;
    logic clk_enable;
    int   errors;
    int   checks;

    next_pc_sequencer_if bus ();

    next_pc_sequencer #(
        .HALT_ADDR(32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_enable(clk_enable),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.branch_taken = 1'b0;
        bus.branch_imm   = 16'h0000;
        bus.jump         = 1'b0;
        bus.jump_index   = 26'h0;
        bus.jump_reg     = 1'b0;
        bus.rs_data      = 32'h0;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        reset      = 1'b0;
        clk_enable = 1'b1;
        bus.pc     = 32'hBFC0_0000;
        idle_inputs();

        // Reset state
        #12;
        chk("rst_new_pc", bus.new_pc, 32'hBFC0_0004);
        chk("rst_active", {31'b0, bus.active}, 32'd1);
        chk("rst_delay", {31'b0, bus.in_delay_slot}, 32'd0);
        chk("rst_misal", {31'b0, bus.target_misaligned}, 32'd0);
        #1 reset = 1'b1;
        step();
        chk("seq_new_pc", bus.new_pc, 32'hBFC0_0004);
        chk("seq_link", bus.link_pc, 32'hBFC0_0008);
        chk("seq_active", {31'b0, bus.active}, 32'd1);

        // Wrap at the top of the address space
        bus.pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap_new_pc", bus.new_pc, 32'h0000_0000);
        chk("wrap_link", bus.link_pc, 32'h0000_0004);

        // Backward branch: target = BFC00014 - 16 = BFC00004
        bus.pc           = 32'hBFC0_0010;
        bus.branch_taken = 1'b1;
        bus.branch_imm   = 16'hFFFC;
        #1;
        chk("br_c0_new_pc", bus.new_pc, 32'hBFC0_0014);
        chk("br_c0_delay", {31'b0, bus.in_delay_slot}, 32'd0);
        step();
        idle_inputs();
        bus.pc = 32'hBFC0_0014;
        #1;
        chk("br_ds_new_pc", bus.new_pc, 32'hBFC0_0004);
        chk("br_ds_delay", {31'b0, bus.in_delay_slot}, 32'd1);
        step();
        bus.pc = 32'hBFC0_0004;
        #1;
        chk("br_tgt_new_pc", bus.new_pc, 32'hBFC0_0008);
        chk("br_tgt_delay", {31'b0, bus.in_delay_slot}, 32'd0);

        // jump_reg outranks jump
        bus.pc         = 32'h1000_0000;
        bus.jump       = 1'b1;
        bus.jump_index = 26'h000_0040;
        bus.jump_reg   = 1'b1;
        bus.rs_data    = 32'h0040_0000;
        step();
        idle_inputs();
        bus.pc = 32'h1000_0004;
        #1;
        chk("pri_jr_tgt", bus.new_pc, 32'h0040_0000);
        step();
        bus.pc         = 32'h1000_0000;
        bus.jump       = 1'b1;
        bus.jump_index = 26'h000_0040;
        step();
        idle_inputs();
        bus.pc = 32'h1000_0004;
        #1;
        chk("pri_j_tgt", bus.new_pc, 32'h1000_0100);
        chk("pri_j_delay", {31'b0, bus.in_delay_slot}, 32'd1);
        step();

        // Stall: branch held with enable low must not latch
        clk_enable       = 1'b0;
        bus.pc           = 32'h0000_2000;
        bus.branch_taken = 1'b1;
        bus.branch_imm   = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_new_pc", bus.new_pc, 32'h0000_2004);
            chk("stall_delay", {31'b0, bus.in_delay_slot}, 32'd0);
        end
        clk_enable = 1'b1;
        step();
        // Branch in the delay slot is ignored
        bus.pc         = 32'h0000_2004;
        bus.branch_imm = 16'h0100;
        #1;
        chk("stall_ds_new_pc", bus.new_pc, 32'h0000_2044);
        chk("stall_ds_delay", {31'b0, bus.in_delay_slot}, 32'd1);
        chk("ds_no_misal", {31'b0, bus.target_misaligned}, 32'd0);
        step();
        idle_inputs();
        bus.pc = 32'h0000_2044;
        #1;
        chk("ds_ignored_new_pc", bus.new_pc, 32'h0000_2048);
        chk("ds_ignored_delay", {31'b0, bus.in_delay_slot}, 32'd0);

        // Misaligned register target
        bus.pc       = 32'h0000_3000;
        bus.jump_reg = 1'b1;
        bus.rs_data  = 32'h0040_0002;
        #1;
        chk("misal_flag", {31'b0, bus.target_misaligned}, 32'd1);
        step();
        idle_inputs();
        bus.pc = 32'h0000_3004;
        #1;
        chk("misal_ds_new_pc", bus.new_pc, 32'h0040_0002);
        chk("misal_ds_delay", {31'b0, bus.in_delay_slot}, 32'd1);

        // Asynchronous reset between edges in the delay slot
        #2 reset = 1'b0;
        #1;
        chk("arst_delay", {31'b0, bus.in_delay_slot}, 32'd0);
        chk("arst_new_pc", bus.new_pc, 32'h0000_3008);
        #1 reset = 1'b1;
        step();
        chk("arst_seq_delay", {31'b0, bus.in_delay_slot}, 32'd0);
        chk("arst_seq_new_pc", bus.new_pc, 32'h0000_3008);

        // Halt: JR to 0, then PC holds and requests are ignored
        bus.pc       = 32'h0000_4000;
        bus.jump_reg = 1'b1;
        bus.rs_data  = 32'h0000_0000;
        step();
        idle_inputs();
        bus.pc = 32'h0000_4004;
        #1;
        chk("halt_ds_new_pc", bus.new_pc, 32'h0000_0000);
        chk("halt_ds_active", {31'b0, bus.active}, 32'd1);
        step();
        bus.branch_taken = 1'b1;
        bus.branch_imm   = 16'h0008;
        for (int i = 0; i < 6; i++) begin
            bus.pc = 32'h0000_0100 * (i + 1);
            #1;
            chk("halt_new_pc", bus.new_pc, 32'h0000_0100 * (i + 1));
            chk("halt_active", {31'b0, bus.active}, 32'd0);
            chk("halt_delay", {31'b0, bus.in_delay_slot}, 32'd0);
            chk("halt_misal", {31'b0, bus.target_misaligned}, 32'd0);
            step();
        end
        idle_inputs();
        bus.pc = 32'h0000_5000;
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("post_halt_active", {31'b0, bus.active}, 32'd1);
        chk("post_halt_new_pc", bus.new_pc, 32'h0000_5004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/next_pc_sequencer.md
Name: next_pc_sequencer

Overview:
- Produces `new_pc` for the CPU's PC register every cycle, and implements MIPS branch-delay-slot sequencing.
- Decode supplies control-transfer requests; the block computes the target and latches it for one instruction.
- `new_pc` points to the delay slot first, then to the target.
- Also generates the link address and detects the halt condition (a jump to `HALT_ADDR`).

Parameters:
- HALT_ADDR, 32'h00000000, target address that ends execution once its delay slot retires.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- clk_enable  input  1  advances state only when 1; same enable as the PC register.
- pc  input  32  current PC (address of the instruction being decoded).
- branch_taken  input  1  conditional branch at `pc` resolved taken.
- branch_imm  input  16  raw branch immediate.
- jump  input  1  J/JAL at `pc`.
- jump_index  input  26  J-type instr_index field.
- jump_reg  input  1  JR/JALR at `pc`.
- rs_data  input  32  register target for JR/JALR.
- new_pc  output  32  next PC value, to the PC register.
- link_pc  output  32  pc+8, the return address for JAL/JALR/BxxAL.
- in_delay_slot  output  1  instruction at `pc` is a delay slot.
- target_misaligned  output  1  the selected target has bits [1:0] != 0.
- active  output  1  1 while executing; 0 once halted.

Behaviour:
- Combinational: `pc_plus4 = pc+4` and `link_pc = pc+8`, both mod 2^32 (wrap at 32'hFFFFFFFC -> 0).
- Target selection, priority jump_reg > jump > branch_taken:
  - JR/JALR: `rs_data`.
  - J/JAL: {pc_plus4[31:28], jump_index, 2'b00}.
  - Branch: pc_plus4 + (sign_extend(branch_imm) << 2), mod 2^32.
- `req = jump_reg | jump | branch_taken`.
- Registers: `state` (SEQ, DELAY, HALT) and `target_q[31:0]`.
- Async reset (`reset`==0): state=SEQ, target_q=0, independent of clk/clk_enable.
- Post-reset outputs: new_pc=pc+4, in_delay_slot=0, active=1, target_misaligned=0 (with no req).
- SEQ state:
  - new_pc=pc_plus4, in_delay_slot=0, active=1.
  - On posedge with clk_enable and req: target_q<=target, state<=DELAY.
  - Otherwise state is unchanged.
- DELAY state (instruction at `pc` is the delay slot):
  - new_pc=target_q, in_delay_slot=1, active=1.
  - On posedge with clk_enable: state<=HALT if target_q==HALT_ADDR, else SEQ.
  - Any req in the delay slot is ignored: no latch, no state change beyond the above.
- HALT state:
  - new_pc=pc (PC holds), in_delay_slot=0, active=0.
  - Stays in HALT until reset; all requests are ignored.
- clk_enable=0: no state or target_q change; outputs still follow current inputs combinationally.
- target_misaligned: combinational, = req & (target[1:0]!=0), valid only in SEQ, 0 in DELAY/HALT. The block still latches the misaligned target; exception handling is outside this block.
- Latency:
  - new_pc responds to `pc` and decode inputs in the same cycle (zero-cycle).
  - Control transfer takes effect two PC updates after the branch: delay slot, then target.
- Reset asserted mid-DELAY: pending target_q is discarded; state returns to SEQ.

Test Plan:
- Reset, then pc=32'hBFC00000 with no req -> new_pc=32'hBFC00004, link_pc=32'hBFC00008, active=1, in_delay_slot=0.
- Branch, pc=32'hBFC00010, branch_taken=1, branch_imm=16'hFFFC:
  - cycle 0 -> new_pc=32'hBFC00014, state -> DELAY.
  - next cycle, pc=32'hBFC00014 -> new_pc=32'hBFC00004, in_delay_slot=1.
- Simultaneous requests:
  - pc=32'h10000000, jump=1, jump_index=26'h0000040, and in the same cycle jump_reg=1, rs_data=32'h00400000 -> latched target=32'h00400000 (jump_reg wins).
  - Repeat with jump_reg=0 -> target=32'h10000100.
- Halt sequence:
  - JR with rs_data=0 -> delay slot new_pc=0.
  - After the delay-slot edge, active=0 and new_pc tracks pc for 5+ cycles with branch_taken=1 (ignored).
  - reset pulse -> active=1.
- Stall and delay-slot rules:
  - Branch taken with clk_enable=0 for 3 cycles -> state stays SEQ and new_pc=pc+4.
  - Then enable -> DELAY.
  - Branch in the delay slot -> ignored; next new_pc equals the first target.
- Misalignment and reset:
  - jump_reg with rs_data=32'h00400002 -> target_misaligned=1 in that cycle.
  - Async reset asserted mid-DELAY, between clock edges -> in_delay_slot drops to 0 immediately.
